// File: rtl/filter_core_multi.sv
// Multi-pump filter controller: REQ/ACK command intake, float-sensor debounce,
// per-channel soft-start and period-aligned PWM from one shared counter.
module filter_core_multi #(
  parameter int unsigned NUM_PUMPS  = 2,
  parameter int unsigned LEVEL_BITS = 4,
  parameter int unsigned PWM_BITS   = 8,
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned STABLE_MS  = 20,
  parameter int unsigned RAMP_DIV   = 1000,
  parameter int unsigned CH_BITS    = (NUM_PUMPS > 1) ? $clog2(NUM_PUMPS) : 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [CH_BITS+LEVEL_BITS-1:0] data,
  input  logic                          req,
  output logic                          ack,
  input  logic                          level_sensor,
  output logic [NUM_PUMPS-1:0]          pwm_pump,
  output logic                          dry_fault,
  output logic                          cmd_reject,
  output logic                          ramp_active
);

  localparam int unsigned StableCycles = CLK_FREQ / 1000 * STABLE_MS;
  localparam int unsigned DbW          = $clog2(StableCycles + 1);
  localparam int unsigned PreW         = $clog2(RAMP_DIV + 1);
  localparam int unsigned DataW        = CH_BITS + LEVEL_BITS;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StAck  = 1'b1;

  logic                  req_meta_q, req_s_q, lvl_meta_q, lvl_s_q;
  logic [0:0]            state_q, state_d;
  logic [DataW-1:0]      data_q, data_d;
  logic                  cmd_valid_q, cmd_valid_d;
  logic                  cmd_reject_q, cmd_reject_d;
  logic                  stable_q, stable_d;
  logic [DbW-1:0]        db_cnt_q, db_cnt_d;
  logic [PreW-1:0]       pre_cnt_q, pre_cnt_d;
  logic                  tick;
  logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic                  pwm_wrap;
  logic [PWM_BITS-1:0]   tgt_q [NUM_PUMPS];
  logic [PWM_BITS-1:0]   tgt_d [NUM_PUMPS];
  logic [PWM_BITS-1:0]   cur_q [NUM_PUMPS];
  logic [PWM_BITS-1:0]   cur_d [NUM_PUMPS];
  logic [PWM_BITS-1:0]   cmp_q [NUM_PUMPS];
  logic [PWM_BITS-1:0]   cmp_d [NUM_PUMPS];
  logic [NUM_PUMPS-1:0]  pwm_q, pwm_d;
  logic [NUM_PUMPS-1:0]  below;
  logic [CH_BITS-1:0]    cmd_ch;
  logic [LEVEL_BITS-1:0] cmd_code;
  logic [PWM_BITS-1:0]   cmd_duty;

  assign cmd_ch   = data_q[DataW-1 -: CH_BITS];
  assign cmd_code = data_q[LEVEL_BITS-1:0];
  assign tick     = (pre_cnt_q == PreW'(RAMP_DIV - 1));
  assign pwm_wrap = &pwm_cnt_q;

  // Handshake: latch once per request; a held req never re-latches.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    cmd_valid_d = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_s_q) begin
          state_d     = StAck;
          data_d      = data;
          cmd_valid_d = 1'b1;
        end
      end
      default: begin
        if (!req_s_q) state_d = StIdle;
      end
    endcase
  end

  // Extremes map to full off / full on; otherwise left-justify the code.
  always_comb begin
    if (cmd_code == '0) begin
      cmd_duty = '0;
    end else if (&cmd_code) begin
      cmd_duty = '1;
    end else begin
      cmd_duty = PWM_BITS'(cmd_code) << (PWM_BITS - LEVEL_BITS);
    end
  end

  assign cmd_reject_d = cmd_valid_q && (32'(cmd_ch) >= NUM_PUMPS);

  always_comb begin
    stable_d = stable_q;
    db_cnt_d = '0;
    if (lvl_s_q != stable_q) begin
      if (db_cnt_q == DbW'(StableCycles - 1)) begin
        stable_d = lvl_s_q;
      end else begin
        db_cnt_d = db_cnt_q + DbW'(1);
      end
    end
  end

  assign pre_cnt_d = tick ? '0 : pre_cnt_q + PreW'(1);
  assign pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);

  always_comb begin
    for (int i = 0; i < NUM_PUMPS; i++) begin
      tgt_d[i] = tgt_q[i];
      if (cmd_valid_q && (cmd_ch == CH_BITS'(i))) tgt_d[i] = cmd_duty;

      cur_d[i] = cur_q[i];
      if (stable_q) begin
        cur_d[i] = '0;
      end else if (tgt_q[i] < cur_q[i]) begin
        cur_d[i] = tgt_q[i];
      end else if (tick && (cur_q[i] < tgt_q[i])) begin
        cur_d[i] = cur_q[i] + PWM_BITS'(1);
      end

      // Compare shadow only moves at the wrap, cleared during a fault so
      // re-entry never resumes at a stale duty.
      cmp_d[i] = stable_q ? '0 : (pwm_wrap ? cur_q[i] : cmp_q[i]);
      pwm_d[i] = !stable_q && (pwm_cnt_q < cmp_q[i]);
      below[i] = cur_q[i] < tgt_q[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_meta_q   <= 1'b0;
      req_s_q      <= 1'b0;
      lvl_meta_q   <= 1'b0;
      lvl_s_q      <= 1'b0;
      state_q      <= StIdle;
      data_q       <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_reject_q <= 1'b0;
      stable_q     <= 1'b1;
      db_cnt_q     <= '0;
      pre_cnt_q    <= '0;
      pwm_cnt_q    <= '0;
      pwm_q        <= '0;
      for (int i = 0; i < NUM_PUMPS; i++) begin
        tgt_q[i] <= '0;
        cur_q[i] <= '0;
        cmp_q[i] <= '0;
      end
    end else begin
      req_meta_q   <= req;
      req_s_q      <= req_meta_q;
      lvl_meta_q   <= level_sensor;
      lvl_s_q      <= lvl_meta_q;
      state_q      <= state_d;
      data_q       <= data_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_reject_q <= cmd_reject_d;
      stable_q     <= stable_d;
      db_cnt_q     <= db_cnt_d;
      pre_cnt_q    <= pre_cnt_d;
      pwm_cnt_q    <= pwm_cnt_d;
      pwm_q        <= pwm_d;
      for (int i = 0; i < NUM_PUMPS; i++) begin
        tgt_q[i] <= tgt_d[i];
        cur_q[i] <= cur_d[i];
        cmp_q[i] <= cmp_d[i];
      end
    end
  end

  assign ack         = (state_q == StAck);
  assign pwm_pump    = pwm_q;
  assign dry_fault   = stable_q;
  assign cmd_reject  = cmd_reject_q;
  assign ramp_active = |below;

endmodule

// File: tb/tb_filter_core_multi.sv
// Directed bench for filter_core_multi: a 2-pump instance for the main flows
// and a 3-pump instance for channel-range rejection.
module tb_filter_core_multi;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       level_sensor = 1'b1;
  logic [4:0] data = '0;
  logic       req = 1'b0;
  logic       ack, dry_fault, cmd_reject, ramp_active;
  logic [1:0] pwm_pump;
  logic [5:0] data3 = '0;
  logic       req3 = 1'b0;
  logic       ack3, dry3, rej3, ramp3;
  logic [2:0] pwm3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  filter_core_multi #(
    .NUM_PUMPS(2), .LEVEL_BITS(4), .PWM_BITS(8),
    .CLK_FREQ(1000), .STABLE_MS(4), .RAMP_DIV(2)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .data(data), .req(req), .ack(ack),
    .level_sensor(level_sensor), .pwm_pump(pwm_pump), .dry_fault(dry_fault),
    .cmd_reject(cmd_reject), .ramp_active(ramp_active)
  );

  filter_core_multi #(
    .NUM_PUMPS(3), .LEVEL_BITS(4), .PWM_BITS(8),
    .CLK_FREQ(1000), .STABLE_MS(4), .RAMP_DIV(2)
  ) u_dut3 (
    .clk(clk), .reset_n(reset_n), .data(data3), .req(req3), .ack(ack3),
    .level_sensor(level_sensor), .pwm_pump(pwm3), .dry_fault(dry3),
    .cmd_reject(rej3), .ramp_active(ramp3)
  );

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic count_high(input int ch, output int cnt);
    cnt = 0;
    for (int k = 0; k < 256; k++) begin
      if (pwm_pump[ch] === 1'b1) cnt++;
      step(1);
    end
  endtask

  task automatic send_cmd(input logic [4:0] d);
    data = d;
    req  = 1'b1;
    for (int k = 0; k < 10 && ack !== 1'b1; k++) step(1);
    n_checks++;
    if (ack !== 1'b1) begin n_fail++; $display("FAIL hs_ack_rise: ack=%b want 1", ack); end
    req = 1'b0;
    for (int k = 0; k < 10 && ack !== 1'b0; k++) step(1);
    n_checks++;
    if (ack !== 1'b0) begin n_fail++; $display("FAIL hs_ack_fall: ack=%b want 0", ack); end
  endtask

  task automatic test_reset;
    #12;
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b want 0", ack); end
    n_checks++; if (pwm_pump !== 2'b00) begin n_fail++; $display("FAIL rst_pwm: got %b want 00", pwm_pump); end
    n_checks++; if (dry_fault !== 1'b1) begin n_fail++; $display("FAIL rst_dry: got %b want 1", dry_fault); end
    n_checks++; if (cmd_reject !== 1'b0 || ramp_active !== 1'b0) begin
      n_fail++; $display("FAIL rst_rej_ramp: got %b%b want 00", cmd_reject, ramp_active); end
    n_checks++; if (ack3 !== 1'b0 || dry3 !== 1'b1) begin
      n_fail++; $display("FAIL rst_dut3: ack3=%b dry3=%b want 0 1", ack3, dry3); end
    reset_n = 1'b1;
    step(4);
    level_sensor = 1'b0;
    step(5);
    n_checks++; if (dry_fault !== 1'b1) begin n_fail++; $display("FAIL dry_early: got %b want 1", dry_fault); end
    step(1);
    n_checks++; if (dry_fault !== 1'b0) begin n_fail++; $display("FAIL dry_fall6: got %b want 0", dry_fault); end
  endtask

  task automatic test_handshake;
    int c0, cnt;
    bit ramp_ok;
    data = 5'b1_1111;
    req  = 1'b1;
    step(2);
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL ack_early: got %b want 0", ack); end
    step(1);
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL ack_rise3: got %b want 1", ack); end
    step(1);
    n_checks++; if (u_dut.tgt_q[1] !== 8'd255) begin
      n_fail++; $display("FAIL tgt1_full: got %0d want 255", u_dut.tgt_q[1]); end
    c0 = int'(u_dut.cur_q[1]);
    step(20);
    n_checks++; if (int'(u_dut.cur_q[1]) !== c0 + 10) begin
      n_fail++; $display("FAIL ramp_rate: got %0d want %0d", u_dut.cur_q[1], c0 + 10); end
    n_checks++; if (ramp_active !== 1'b1) begin n_fail++; $display("FAIL ramp_active_on: got %b want 1", ramp_active); end
    req = 1'b0;
    step(2);
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL ack_hold: got %b want 1", ack); end
    step(1);
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL ack_fall3: got %b want 0", ack); end
    ramp_ok = 1'b1;
    for (int k = 0; k < 600 && u_dut.cur_q[1] !== 8'd255; k++) begin
      if (ramp_active !== 1'b1) ramp_ok = 1'b0;
      step(1);
    end
    n_checks++; if (u_dut.cur_q[1] !== 8'd255 || !ramp_ok) begin
      n_fail++; $display("FAIL ramp_full: cur=%0d ramp_ok=%0d want 255 1", u_dut.cur_q[1], ramp_ok); end
    n_checks++; if (ramp_active !== 1'b0) begin n_fail++; $display("FAIL ramp_active_off: got %b want 0", ramp_active); end
    step(300);
    count_high(1, cnt);
    n_checks++; if (cnt !== 255) begin n_fail++; $display("FAIL pwm1_full: high=%0d want 255", cnt); end
  endtask

  task automatic test_ramp_down;
    int cnt;
    send_cmd(5'b0_1000);
    n_checks++; if (u_dut.tgt_q[0] !== 8'd128) begin
      n_fail++; $display("FAIL tgt0_128: got %0d want 128", u_dut.tgt_q[0]); end
    step(100);
    n_checks++; if (!(u_dut.cur_q[0] > 8'd32 && u_dut.cur_q[0] < 8'd128)) begin
      n_fail++; $display("FAIL cur0_mid: got %0d want 33..127", u_dut.cur_q[0]); end
    data = 5'b0_0010;
    req  = 1'b1;
    step(4);
    n_checks++; if (u_dut.tgt_q[0] !== 8'd32 || u_dut.cur_q[0] <= 8'd32) begin
      n_fail++; $display("FAIL tgt0_32: tgt=%0d cur=%0d want 32 >32", u_dut.tgt_q[0], u_dut.cur_q[0]); end
    step(1);
    n_checks++; if (u_dut.cur_q[0] !== 8'd32) begin
      n_fail++; $display("FAIL cur0_drop: got %0d want 32", u_dut.cur_q[0]); end
    req = 1'b0;
    step(3);
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL ack_fall_rd: got %b want 0", ack); end
    step(300);
    count_high(0, cnt);
    n_checks++; if (cnt !== 32) begin n_fail++; $display("FAIL pwm0_32: high=%0d want 32", cnt); end
  endtask

  task automatic test_invalid_channel;
    data3 = 6'b11_0101;
    req3  = 1'b1;
    step(3);
    n_checks++; if (ack3 !== 1'b1 || rej3 !== 1'b0) begin
      n_fail++; $display("FAIL inv_ack: ack3=%b rej3=%b want 1 0", ack3, rej3); end
    step(1);
    n_checks++; if (rej3 !== 1'b1) begin n_fail++; $display("FAIL inv_pulse: got %b want 1", rej3); end
    step(1);
    n_checks++; if (rej3 !== 1'b0) begin n_fail++; $display("FAIL inv_pulse_len: got %b want 0", rej3); end
    n_checks++; if (u_dut3.tgt_q[0] !== 8'd0 || u_dut3.tgt_q[1] !== 8'd0 || u_dut3.tgt_q[2] !== 8'd0) begin
      n_fail++; $display("FAIL inv_tgt: got %0d %0d %0d want 0 0 0",
                         u_dut3.tgt_q[0], u_dut3.tgt_q[1], u_dut3.tgt_q[2]); end
    req3 = 1'b0;
    step(3);
    n_checks++; if (ack3 !== 1'b0) begin n_fail++; $display("FAIL inv_ack_fall: got %b want 0", ack3); end
    data3 = 6'b10_0101;
    req3  = 1'b1;
    step(4);
    n_checks++; if (u_dut3.tgt_q[2] !== 8'd80 || rej3 !== 1'b0) begin
      n_fail++; $display("FAIL ch2_valid: tgt=%0d rej=%b want 80 0", u_dut3.tgt_q[2], rej3); end
    req3 = 1'b0;
    step(3);
  endtask

  task automatic test_dry_run;
    bit quiet;
    level_sensor = 1'b1;
    step(3);
    level_sensor = 1'b0;
    quiet = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (dry_fault !== 1'b0) quiet = 1'b0;
      step(1);
    end
    n_checks++; if (!quiet) begin n_fail++; $display("FAIL glitch: dry_fault rose, want 0"); end
    level_sensor = 1'b1;
    step(4);
    level_sensor = 1'b0;
    step(1);
    n_checks++; if (dry_fault !== 1'b0) begin n_fail++; $display("FAIL dry_early2: got %b want 0", dry_fault); end
    step(1);
    n_checks++; if (dry_fault !== 1'b1) begin n_fail++; $display("FAIL dry_rise6: got %b want 1", dry_fault); end
    step(1);
    n_checks++; if (pwm_pump !== 2'b00 || u_dut.cur_q[0] !== 8'd0 || u_dut.cur_q[1] !== 8'd0) begin
      n_fail++; $display("FAIL dry_off: pwm=%b cur=%0d,%0d want 00 0,0",
                         pwm_pump, u_dut.cur_q[0], u_dut.cur_q[1]); end
    n_checks++; if (u_dut.tgt_q[0] !== 8'd32 || u_dut.tgt_q[1] !== 8'd255) begin
      n_fail++; $display("FAIL tgt_kept: got %0d,%0d want 32,255", u_dut.tgt_q[0], u_dut.tgt_q[1]); end
    for (int k = 0; k < 20 && dry_fault !== 1'b0; k++) step(1);
    n_checks++; if (dry_fault !== 1'b0) begin n_fail++; $display("FAIL dry_clear: got %b want 0", dry_fault); end
    step(40);
    n_checks++; if (u_dut.cur_q[0] !== 8'd20 || u_dut.cur_q[1] !== 8'd20) begin
      n_fail++; $display("FAIL reramp40: got %0d,%0d want 20,20", u_dut.cur_q[0], u_dut.cur_q[1]); end
    step(200);
    n_checks++; if (u_dut.cur_q[0] !== 8'd32 || u_dut.cur_q[1] !== 8'd120) begin
      n_fail++; $display("FAIL reramp240: got %0d,%0d want 32,120", u_dut.cur_q[0], u_dut.cur_q[1]); end
  endtask

  task automatic test_reset_mid;
    data = 5'b0_1111;
    req  = 1'b1;
    step(3);
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL mid_ack: got %b want 1", ack); end
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (ack !== 1'b0 || pwm_pump !== 2'b00 || dry_fault !== 1'b1 ||
                    cmd_reject !== 1'b0 || ramp_active !== 1'b0) begin
      n_fail++; $display("FAIL mid_rst_out: ack=%b pwm=%b dry=%b rej=%b ramp=%b want 0 00 1 0 0",
                         ack, pwm_pump, dry_fault, cmd_reject, ramp_active); end
    n_checks++; if (u_dut.tgt_q[1] !== 8'd0 || u_dut.cur_q[1] !== 8'd0) begin
      n_fail++; $display("FAIL mid_rst_state: tgt=%0d cur=%0d want 0 0", u_dut.tgt_q[1], u_dut.cur_q[1]); end
    req = 1'b0;
    #2 reset_n = 1'b1;
    step(10);
    n_checks++; if (dry_fault !== 1'b0) begin n_fail++; $display("FAIL mid_dry: got %b want 0", dry_fault); end
    send_cmd(5'b1_0100);
    n_checks++; if (u_dut.tgt_q[1] !== 8'd64) begin
      n_fail++; $display("FAIL mid_fresh: got %0d want 64", u_dut.tgt_q[1]); end
    step(20);
    n_checks++; if (ramp_active !== 1'b1) begin n_fail++; $display("FAIL mid_ramp: got %b want 1", ramp_active); end
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_ramp_down();
    test_invalid_channel();
    test_dry_run();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d checks done", n_checks);
    $fatal(1);
  end

endmodule
